// File: rtl/reg_idx_encoder_if.sv
// Handshake bundle between the bitmap source/consumer and the sequential index encoder.
// The encoder is the slave: it takes load/req/clr/ready and drives rdy/valid/idx/done.
interface reg_idx_encoder_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         load;
    logic [N-1:0] req;
    logic         clr;
    logic         ready;
    logic         rdy;
    logic         valid;
    logic [W-1:0] idx;
    logic         done;

    modport master (output load, req, clr, ready, input rdy, valid, idx, done);
    modport slave  (input load, req, clr, ready, output rdy, valid, idx, done);
endinterface

// File: rtl/reg_idx_encoder.sv
// Sequential N-to-log2(N) encoder: captures a request bitmap and emits the index of
// each set bit, lowest first, one per valid/ready handshake, then pulses done.
module reg_idx_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_idx_encoder_if.slave bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] idx_q, idx_d;
    logic         done_q, done_d;
    logic [N-1:0] pend_left;

    // Scan from the top so the lowest set bit is the last one written.
    function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    assign pend_left = pend_q & ~(N'(1) << idx_q);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        if (bus.clr) begin
            state_d = IDLE;
            pend_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        if (bus.req != '0) begin
                            pend_d  = bus.req;
                            state_d = EMIT;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.ready) begin
                        pend_d = pend_left;
                        if (pend_left == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Index is registered from the next bitmap so outputs never see inputs directly.
        idx_d = lowest_idx(pend_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign bus.rdy   = (state_q == IDLE);
    assign bus.valid = (state_q == EMIT);
    assign bus.idx   = idx_q;
    assign bus.done  = done_q;
endmodule
